// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the VGA scan-out path.
//   - 640x480@60 Hz raster timing (visible, front porch, sync, total).
//   - PIPE_LAT: clocks from counter state to output pins.
//   - Counter, address and pixel types; the per-stage flag bundle that
//     travels alongside the memory read.
//   - in_span(): half-open range test used for sync and window decoding.
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int H_VIS    = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_TOT    = 800;
  localparam int V_VIS    = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_TOT    = 525;
  localparam int PIPE_LAT = 3;

  localparam int CNT_W = 12;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [31:0]      addr_t;
  typedef logic [7:0]       pix_t;

  // Raster flags computed from the counters, delayed together so they stay
  // aligned with the pixel returned by the RAM.
  typedef struct packed {
    logic visible;
    logic in_win;
    logic hsync_n;
    logic vsync_n;
    logic frame_start;
  } stage_flags_t;

  // Idle value keeps both syncs inactive, so leaving reset never produces a
  // spurious sync pulse while the pipeline fills.
  localparam stage_flags_t FLAGS_IDLE = '{
    visible:     1'b0,
    in_win:      1'b0,
    hsync_n:     1'b1,
    vsync_n:     1'b1,
    frame_start: 1'b0
  };

  // True when lo <= pos < lo+len.
  function automatic logic in_span(input cnt_t pos, input int lo, input int len);
    return (int'(pos) >= lo) && (int'(pos) < lo + len);
  endfunction

endpackage

// File: rtl/vga_frame_reader_if.sv
// ---------------------------------------------------------------------------
// vga_frame_reader_if
// Bundles the memory port-b read path and the VGA DAC pins of the frame
// reader.
//   master (frame reader): drives address, write controls (tied inactive),
//                          hsync/vsync/blank_n/sync_n, r/g/b, frame_start;
//                          receives q_b.
//   slave  (RAM + DAC)   : the opposite directions.
// ---------------------------------------------------------------------------
interface vga_frame_reader_if;
  import vga_pkg::*;

  addr_t address;      // port-b read address
  pix_t  q_b;          // port-b read data, one clock after address capture
  logic  wren_b;       // port-b write enable, never asserted
  pix_t  data_b;       // port-b write data, never used
  logic  hsync;        // active low
  logic  vsync;        // active low
  logic  blank_n;      // 1 in the visible area
  logic  sync_n;       // no sync-on-green
  pix_t  r;
  pix_t  g;
  pix_t  b;
  logic  frame_start;  // one pulse with output pixel (0,0)

  modport master (
    output address, wren_b, data_b,
    output hsync, vsync, blank_n, sync_n, r, g, b, frame_start,
    input  q_b
  );

  modport slave (
    input  address, wren_b, data_b,
    input  hsync, vsync, blank_n, sync_n, r, g, b, frame_start,
    output q_b
  );

endinterface

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Free-running horizontal/vertical raster counters and the raw (stage-0)
// timing decodes derived from them.
//   clk, rst    : pixel clock, asynchronous active-low reset
//   h_cnt/v_cnt : current raster position
//   visible     : position lies in the active area
//   hsync_n     : low during the horizontal sync interval
//   vsync_n     : low during the vertical sync lines
//   frame_start : position is (0,0)
// ---------------------------------------------------------------------------
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VIS,
  parameter int H_FRONT   = H_FP,
  parameter int H_SYNC_W  = H_SYNC,
  parameter int H_TOTAL   = H_TOT,
  parameter int V_VISIBLE = V_VIS,
  parameter int V_FRONT   = V_FP,
  parameter int V_SYNC_W  = V_SYNC,
  parameter int V_TOTAL   = V_TOT
) (
  input  logic clk,
  input  logic rst,
  output cnt_t h_cnt,
  output cnt_t v_cnt,
  output logic visible,
  output logic hsync_n,
  output logic vsync_n,
  output logic frame_start
);

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

  cnt_t h_cnt_q, h_cnt_d;
  cnt_t v_cnt_q, v_cnt_d;

  always_comb begin
    // NOTE: defaults come first so every path assigns every variable; a
    // missing branch here would otherwise infer a latch.
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop in
  // the design samples values from before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt       = h_cnt_q;
  assign v_cnt       = v_cnt_q;
  assign visible     = in_span(h_cnt_q, 0, H_VISIBLE) && in_span(v_cnt_q, 0, V_VISIBLE);
  assign hsync_n     = !in_span(h_cnt_q, H_VISIBLE + H_FRONT, H_SYNC_W);
  assign vsync_n     = !in_span(v_cnt_q, V_VISIBLE + V_FRONT, V_SYNC_W);
  assign frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/vga_frame_reader.sv
// ---------------------------------------------------------------------------
// vga_frame_reader
// Scans an IMG_W x IMG_H 8-bit grayscale image out of memory port b and
// presents it on a VGA DAC, centred in the visible raster at (X0,Y0).
//   clk        : pixel clock, shared with memory port b
//   rst        : asynchronous active-low reset
//   display_en : show the image; latched once per frame at raster (0,0)
//   bus        : port-b address/q_b and the VGA pins (master side)
//
// Pipeline (3 clocks from counter state to pins, same for sync and pixel):
//   stage 0 : counters, sync/visible decode, window test
//   stage 1 : address register (RAM captures it on the next edge)
//   stage 2 : RAM returns q_b
//   output  : grey level mux into r/g/b, delayed flags to the sync pins
// ---------------------------------------------------------------------------
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int    IMG_W     = 256,
  parameter int    IMG_H     = 256,
  parameter addr_t BASE_ADDR = '0,
  parameter int    X0        = 192,
  parameter int    Y0        = 112,
  parameter pix_t  BG        = 8'h00,
  parameter int    H_VISIBLE = H_VIS,
  parameter int    H_FRONT   = H_FP,
  parameter int    H_SYNC_W  = H_SYNC,
  parameter int    H_TOTAL   = H_TOT,
  parameter int    V_VISIBLE = V_VIS,
  parameter int    V_FRONT   = V_FP,
  parameter int    V_SYNC_W  = V_SYNC,
  parameter int    V_TOTAL   = V_TOT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                display_en,
  vga_frame_reader_if.master  bus
);

  localparam cnt_t X_LAST = cnt_t'(X0 + IMG_W - 1);

  // ---------------- stage 0: raster timing and window test ----------------
  cnt_t h_cnt;
  cnt_t v_cnt;
  logic visible_s0;
  logic hsync_n_s0;
  logic vsync_n_s0;
  logic fstart_s0;
  logic in_win_s0;

  vga_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC_W  (H_SYNC_W),
    .H_TOTAL   (H_TOTAL),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC_W  (V_SYNC_W),
    .V_TOTAL   (V_TOTAL)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .visible     (visible_s0),
    .hsync_n     (hsync_n_s0),
    .vsync_n     (vsync_n_s0),
    .frame_start (fstart_s0)
  );

  logic en_lat_q, en_lat_d;

  assign in_win_s0 = visible_s0
                  && in_span(h_cnt, X0, IMG_W)
                  && in_span(v_cnt, Y0, IMG_H)
                  && en_lat_q;

  stage_flags_t flags_s0;
  assign flags_s0 = '{
    visible:     visible_s0,
    in_win:      in_win_s0,
    hsync_n:     hsync_n_s0,
    vsync_n:     vsync_n_s0,
    frame_start: fstart_s0
  };

  // ---------------- stage 1: address generation ----------------
  // row_base tracks (v-Y0)*IMG_W: cleared each frame, advanced by IMG_W
  // after the last window pixel of a row, so no multiplier is needed.
  addr_t row_base_q, row_base_d;
  addr_t addr_q, addr_d;
  addr_t col_off;

  assign col_off = addr_t'(h_cnt) - addr_t'(X0);

  // ---------------- delay line and output register ----------------
  stage_flags_t flags_d1_q, flags_d1_d;
  stage_flags_t flags_d2_q, flags_d2_d;
  pix_t         pix_q, pix_d;
  logic         blank_n_q, blank_n_d;
  logic         hsync_q, hsync_d;
  logic         vsync_q, vsync_d;
  logic         fstart_q, fstart_d;

  always_comb begin
    en_lat_d   = en_lat_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;

    // display_en only matters at frame start; mid-frame changes wait.
    if (fstart_s0) begin
      en_lat_d   = display_en;
      row_base_d = '0;
    end

    // Outside the window the address holds, so the RAM sees no activity.
    if (in_win_s0) begin
      addr_d = BASE_ADDR + row_base_q + col_off;
      if (h_cnt == X_LAST) begin
        row_base_d = row_base_q + addr_t'(IMG_W);
      end
    end

    flags_d1_d = flags_s0;
    flags_d2_d = flags_d1_q;

    // flags_d2_q lines up with q_b: both describe the same raster position.
    if (flags_d2_q.in_win) begin
      pix_d = bus.q_b;
    end else if (flags_d2_q.visible) begin
      pix_d = BG;
    end else begin
      pix_d = '0;
    end
    blank_n_d = flags_d2_q.visible;
    hsync_d   = flags_d2_q.hsync_n;
    vsync_d   = flags_d2_q.vsync_n;
    fstart_d  = flags_d2_q.frame_start;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_lat_q   <= 1'b0;
      row_base_q <= '0;
      addr_q     <= BASE_ADDR;
      flags_d1_q <= FLAGS_IDLE;
      flags_d2_q <= FLAGS_IDLE;
      pix_q      <= '0;
      blank_n_q  <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      fstart_q   <= 1'b0;
    end else begin
      en_lat_q   <= en_lat_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      flags_d1_q <= flags_d1_d;
      flags_d2_q <= flags_d2_d;
      pix_q      <= pix_d;
      blank_n_q  <= blank_n_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      fstart_q   <= fstart_d;
    end
  end

  // ---------------- pins ----------------
  assign bus.address     = addr_q;
  assign bus.wren_b      = 1'b0;
  assign bus.data_b      = '0;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.blank_n     = blank_n_q;
  assign bus.sync_n      = 1'b0;
  assign bus.r           = pix_q;
  assign bus.g           = pix_q;
  assign bus.b           = pix_q;
  assign bus.frame_start = fstart_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_reader
// Two instances share clk/rst/display_en:
//   u_small : reduced raster and image so whole frames fit in a short run;
//             every cycle is compared with a position-based reference model.
//   u_full  : default 640x480 timing; first lines checked for sync timing.
// ---------------------------------------------------------------------------
module tb_vga_frame_reader;
  import vga_pkg::*;

  // Reduced raster for u_small
  localparam int HV = 64, HFP = 4, HS = 8, HT = 84;
  localparam int VV = 48, VFP = 3, VS = 2, VT = 56;
  localparam int W = 32, H = 24, X0 = 16, Y0 = 12;
  localparam int BASE = 100;
  localparam logic [7:0] BG = 8'h40;
  localparam int FRAME = HT * VT;
  localparam int LAST  = BASE + W * H - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic display_en = 1'b1;

  always #20 clk = ~clk;

  vga_frame_reader_if bus_s ();
  vga_frame_reader_if bus_f ();

  vga_frame_reader #(
    .IMG_W(W), .IMG_H(H), .BASE_ADDR(32'(BASE)), .X0(X0), .Y0(Y0), .BG(BG),
    .H_VISIBLE(HV), .H_FRONT(HFP), .H_SYNC_W(HS), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_FRONT(VFP), .V_SYNC_W(VS), .V_TOTAL(VT)
  ) u_small (
    .clk(clk), .rst(rst), .display_en(display_en), .bus(bus_s)
  );

  vga_frame_reader u_full (
    .clk(clk), .rst(rst), .display_en(display_en), .bus(bus_f)
  );

  // Synchronous RAM model for the small instance; data for the full one
  // is irrelevant in the lines it runs through.
  logic [7:0] mem [0:1023];
  always @(posedge clk) bus_s.q_b <= mem[bus_s.address[9:0]];
  assign bus_f.q_b = 8'h00;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // ---------------- reference model ----------------
  int          n_edges;          // clock edges since reset release
  logic        en_hist [0:15];   // display_en seen at each frame start
  logic [31:0] exp_addr;

  function automatic logic win_at(input int h, input int v, input logic en);
    return h < HV && v < VV && h >= X0 && h < X0 + W && v >= Y0 && v < Y0 + H && en;
  endfunction

  // Raster position advances one per edge from (0,0); the address register
  // holds the most recent window pixel's address.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_edges  <= 0;
      exp_addr <= 32'(BASE);
    end else begin : model_step
      int f, pos, h, v;
      f   = n_edges / FRAME;
      pos = n_edges % FRAME;
      h   = pos % HT;
      v   = pos / HT;
      if (pos == 0 && f < 16) en_hist[f] <= display_en;
      if (f < 16 && win_at(h, v, en_hist[f]))
        exp_addr <= 32'(BASE + (v - Y0) * W + (h - X0));
      n_edges <= n_edges + 1;
    end
  end

  // Outputs seen after n edges describe raster position n-PIPE_LAT.
  function automatic logic [69:0] expect_now(input int n, input logic rst_v, input logic [31:0] ea);
    int p, f, pos, h, v;
    logic vis, win, hs, vs, fs;
    logic [7:0] pix;
    if (!rst_v || n < PIPE_LAT) return {6'b110000, 8'h00, 24'h0, ea};
    p   = n - PIPE_LAT;
    f   = p / FRAME;
    pos = p % FRAME;
    h   = pos % HT;
    v   = pos / HT;
    vis = h < HV && v < VV;
    win = (f < 16) && win_at(h, v, en_hist[f]);
    hs  = !(h >= HV + HFP && h < HV + HFP + HS);
    vs  = !(v >= VV + VFP && v < VV + VFP + VS);
    fs  = (pos == 0);
    pix = win ? mem[BASE + (v - Y0) * W + (h - X0)] : (vis ? BG : 8'h00);
    return {hs, vs, vis, fs, 1'b0, 1'b0, 8'h00, pix, pix, pix, ea};
  endfunction

  logic [7:0]  cap_pix   [0:FRAME-1];
  logic        cap_blank [0:FRAME-1];
  logic [31:0] prev_addr = 32'(BASE);
  int          last_cnt = 0;
  int          addr_changes = 0;

  always @(negedge clk) begin : monitor
    logic [69:0] obs, exp_v;
    obs = {bus_s.hsync, bus_s.vsync, bus_s.blank_n, bus_s.frame_start, bus_s.sync_n,
           bus_s.wren_b, bus_s.data_b, bus_s.r, bus_s.g, bus_s.b, bus_s.address};
    exp_v = expect_now(n_edges, rst, exp_addr);
    check((obs === exp_v) ? "stream" : $sformatf("stream n=%0d rst=%0b", n_edges, rst),
          80'(obs), 80'(exp_v));
    if (rst && n_edges >= PIPE_LAT && n_edges - PIPE_LAT < FRAME) begin
      cap_pix[n_edges - PIPE_LAT]   = bus_s.r;
      cap_blank[n_edges - PIPE_LAT] = bus_s.blank_n;
    end
    if (bus_s.address != prev_addr) begin
      addr_changes++;
      if (bus_s.address == 32'(LAST)) last_cnt++;
    end
    prev_addr = bus_s.address;
  end

  task automatic wait_state(input int target);
    int guard = 0;
    while (n_edges != target && guard < 3 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("reach_state_%0d", target), 80'(n_edges), 80'(target));
  endtask

  // ---------------- frame-0 spot table ----------------
  typedef struct {
    int   h;
    int   v;
    logic blank;     // expected blank_n
    logic from_mem;  // pixel comes from mem[BASE+off]
    int   off;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int snap, k, fs_first, fs_second;
    logic [7:0] exp_pix;

    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) en_hist[i] = 1'b0;

    tbl[0]  = '{X0,         Y0,         1'b1, 1'b1, 0};
    tbl[1]  = '{X0 + 1,     Y0,         1'b1, 1'b1, 1};
    tbl[2]  = '{X0,         Y0 + 1,     1'b1, 1'b1, W};
    tbl[3]  = '{X0 + W - 1, Y0 + H - 1, 1'b1, 1'b1, W * H - 1};
    tbl[4]  = '{X0 - 1,     Y0,         1'b1, 1'b0, 0};
    tbl[5]  = '{X0 + W,     Y0,         1'b1, 1'b0, 0};
    tbl[6]  = '{X0,         Y0 - 1,     1'b1, 1'b0, 0};
    tbl[7]  = '{X0,         Y0 + H,     1'b1, 1'b0, 0};
    tbl[8]  = '{0,          0,          1'b1, 1'b0, 0};
    tbl[9]  = '{70,         5,          1'b0, 1'b0, 0};
    tbl[10] = '{10,         50,         1'b0, 1'b0, 0};

    #5 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values on the full-size instance
    check("full_reset", 80'({bus_f.hsync, bus_f.vsync, bus_f.blank_n, bus_f.frame_start,
                             bus_f.sync_n, bus_f.wren_b, bus_f.r, bus_f.g, bus_f.b, bus_f.address}),
          80'({6'b110000, 24'h0, 32'h0}));

    rst = 1'b1;

    // Full timing: hsync falls 656+3 clocks after release, 96 wide, 800 period
    k = 0;
    while (bus_f.hsync && k < 2000) begin @(negedge clk); k++; end
    check("hsync_first_fall", 80'(n_edges), 80'(H_VIS + H_FP + PIPE_LAT));
    k = 0;
    while (!bus_f.hsync && k < 2000) begin @(negedge clk); k++; end
    check("hsync_width", 80'(k), 80'(H_SYNC));
    check("full_blank_in_hblank", 80'({bus_f.blank_n, bus_f.r}), 80'(0));
    k = 0;
    while (bus_f.hsync && k < 2000) begin @(negedge clk); k++; end
    check("hsync_period", 80'(n_edges), 80'(H_VIS + H_FP + PIPE_LAT + H_TOT));
    check("full_vsync_idle", 80'(bus_f.vsync), 80'(1));

    // Frame 0 captured: spot checks
    wait_state(FRAME + PIPE_LAT);
    for (int i = 0; i < 11; i++) begin
      int idx;
      idx     = tbl[i].v * HT + tbl[i].h;
      exp_pix = tbl[i].from_mem ? mem[BASE + tbl[i].off] : (tbl[i].blank ? BG : 8'h00);
      check($sformatf("table(%0d,%0d)", tbl[i].h, tbl[i].v),
            80'({cap_blank[idx], cap_pix[idx]}), 80'({tbl[i].blank, exp_pix}));
    end

    // Disable mid-frame 1: frame 1 unaffected, frame 2 shows BG, address holds
    wait_state(FRAME + 20 * HT);
    display_en = 1'b0;
    wait_state(2 * FRAME);
    check("last_addr_once_per_frame", 80'(last_cnt), 80'(2));
    snap = addr_changes;
    wait_state(3 * FRAME - 10);
    check("disabled_addr_changes", 80'(addr_changes - snap), 80'(0));
    check("disabled_addr_value", 80'(bus_s.address), 80'(LAST));
    display_en = 1'b1;

    // Reset mid-line in frame 3 at h=30, v=15
    wait_state(3 * FRAME + 15 * HT + 30);
    #2 rst = 1'b0;
    #1;
    check("midline_reset_small", 80'({bus_s.hsync, bus_s.vsync, bus_s.blank_n, bus_s.frame_start,
                                      bus_s.r, bus_s.g, bus_s.b, bus_s.address}),
          80'({4'b1100, 24'h0, 32'(BASE)}));
    check("midline_reset_full", 80'({bus_f.hsync, bus_f.blank_n, bus_f.address}),
          80'({2'b10, 32'h0}));
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Random display_en activity over three frames, model follows
    fs_first  = -1;
    fs_second = -1;
    display_en = 1'($urandom);
    for (int i = 1; i <= 3 * FRAME + 4; i++) begin
      @(negedge clk);
      if (bus_s.frame_start) begin
        if (fs_first < 0) fs_first = n_edges;
        else if (fs_second < 0) fs_second = n_edges;
      end
      if ($urandom_range(0, 199) == 0) display_en = ~display_en;
    end
    check("frame_start_after_reset", 80'(fs_first), 80'(PIPE_LAT));
    check("frame_start_period", 80'(fs_second - fs_first), 80'(FRAME));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Downstream scan-out stage for the classic-filters processor.
- Continuously reads the processed 8-bit grayscale image through the external read port (port b) of the shared data memory.
- Drives a 640x480@60 Hz VGA DAC interface, placing the image in a centred window.
- Absorbs the synchronous-RAM read latency so pixel data and sync signals leave aligned.

Parameters:
- IMG_W, 256, image width in pixels.
- IMG_H, 256, image height in pixels.
- BASE_ADDR, 0, port-b word address of image pixel (0,0); raster order, one byte per address.
- X0, 192, first visible column of the image window.
- Y0, 112, first visible row of the image window.
- BG, 8'h00, grey level shown in visible area outside the window or while display is disabled.

Ports:
- clk  in  1  25 MHz pixel clock (same clock as memory port b).
- rst  in  1  asynchronous, active-low reset.
- display_en  in  1  show image when 1; sampled only at frame start.
- q_b  in  8  pixel data from memory port b, valid one clock after address is registered by the RAM.
- address  out  32  memory port-b read address.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- blank_n  out  1  1 during visible area.
- sync_n  out  1  tied 0 (no sync-on-green).
- r  out  8  red channel.
- g  out  8  green channel.
- b  out  8  blue channel.
- frame_start  out  1  one-cycle pulse, aligned with output pixel (0,0).

Behaviour:
- Reset (rst=0, async):
  - h_cnt=0, v_cnt=0, pipeline cleared, en_lat=0.
  - address=BASE_ADDR, hsync=1, vsync=1, blank_n=0, r=g=b=0, frame_start=0.
- Counters:
  - h_cnt 0..799 wraps to 0; v_cnt increments on h wrap, 0..524 wraps to 0.
  - Visible area: h<640 && v<480.
  - hsync low for h in 656..751; vsync low for v in 490..491 (stage-0 values).
- Frame enable:
  - en_lat <= display_en when h_cnt==0 && v_cnt==0.
  - A mid-frame change of display_en has no effect until the next frame.
- Stage 0 window test:
  - in_win = visible && X0<=h<X0+IMG_W && Y0<=v<Y0+IMG_H && en_lat.
- Stage 1 (address register):
  - address <= BASE_ADDR + (v-Y0)*IMG_W + (h-X0) when in_win, else held.
  - Multiply folded into a running row-base register: cleared at frame start, incremented by IMG_W at the end of each window row. No multiplier.
  - Width: address computed in 32 bits; no wrap within IMG_W*IMG_H.
- Stage 2: RAM returns q_b.
- Output register:
  - Inputs are the stage-2 q_b, plus visible, in_win, hsync, vsync and frame-start flags each delayed 2 cycles.
  - r=g=b = q_b if in_win_d2; BG if visible_d2 && !in_win_d2; 0 otherwise.
  - blank_n = visible_d2.
  - Total latency from counter state to pins: 3 clocks, identical for sync and pixel paths.
- Boundaries:
  - Last window pixel (X0+IMG_W-1, Y0+IMG_H-1) reads BASE_ADDR+IMG_W*IMG_H-1.
  - Next window pixel read is BASE_ADDR on the following enabled frame.
  - Reset mid-line: outputs go to reset values immediately. The scan restarts at (0,0) with the first sync pulses after 656 clocks.
- Read-only: never asserts a write; port-b write controls stay tied 0 at the top level.

Decomposition:
- Package vga_pkg: H_VIS=640, H_FP=16, H_SYNC=96, H_TOT=800, V_VIS=480, V_FP=10, V_SYNC=2, V_TOT=525, PIPE_LAT=3.
- Sub-module vga_timing: h/v counters plus raw stage-0 hsync/vsync/visible/frame-start.
- vga_frame_reader contains the window logic, address generator and delay pipeline.

Test Plan:
- Reset release → hsync falls 656+3 clocks later for 96 clocks; vsync low during lines 490-491; period 800 clocks per line, 420000 per frame.
- Memory model, mem[i]=i[7:0], display_en=1 → screen pixel (192,112) gets r=g=b=8'h00, (193,112) gets 8'h01, (447,367) gets 8'hFF; address=65535 issued once per frame.
- Pixel (191,112) and (448,112) → BG; h=700 → r=g=b=0, blank_n=0.
- display_en toggled 1→0 at line 200 → current frame unchanged; next frame's window shows BG and address stays constant.
- rst pulsed low at h=300, v=150 → outputs take reset values within the same cycle; after release, frame_start pulses exactly 3 clocks later, then again after 420000 clocks.
- Alignment check: over a full frame, the pixel emitted with blank_n=1 at output column c matches mem[addr] for the address issued 2 clocks earlier.
